// File: rtl/unload_numbers_if.sv
// Word-triple stream carrying n/d/c out of unload_numbers under a valid/ready handshake.
interface unload_numbers_if;
  logic [31:0] n;
  logic [31:0] d;
  logic [31:0] c;
  logic        valid;
  logic        ready;
  logic        last;
  logic [5:0]  idx;

  modport master (output n, d, c, valid, last, idx, input ready);
  modport slave  (input n, d, c, valid, last, idx, output ready);
endinterface

// File: rtl/unload_numbers.sv
// Captures three WORDS-word operands at once and streams them out as 32-bit
// (n, d, c) triples, most-significant word first.
module unload_numbers #(
  parameter int unsigned WORDS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [32*WORDS-1:0]   primeNum,
  input  logic [32*WORDS-1:0]   privateKey,
  input  logic [32*WORDS-1:0]   cipher,
  unload_numbers_if.master      out_if,
  output logic                  busy,
  output logic                  done,
  output logic [5:0]            count
);

  localparam int unsigned W        = 32 * WORDS;
  localparam logic [5:0]  LAST_IDX = 6'(WORDS - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   np_q, np_d, dp_q, dp_d, cp_q, cp_d;
  logic [W-1:0]   np_sh, dp_sh, cp_sh;
  logic [31:0]    n_q, n_d, d_q, d_d, c_q, c_d;
  logic           valid_q, valid_d, last_q, last_d;
  logic           busy_q, busy_d, done_q, done_d;
  logic [5:0]     idx_q, idx_d, count_q, count_d;

  // Next-state: capture in IDLE, shift one word per handshake in SEND.
  always_comb begin
    state_d = state_q;
    np_d    = np_q;
    dp_d    = dp_q;
    cp_d    = cp_q;
    n_d     = n_q;
    d_d     = d_q;
    c_d     = c_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    count_d = count_q;
    done_d  = 1'b0;
    np_sh   = np_q << 32;
    dp_sh   = dp_q << 32;
    cp_sh   = cp_q << 32;

    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SEND;
          np_d    = primeNum;
          dp_d    = privateKey;
          cp_d    = cipher;
          n_d     = primeNum[W-1 -: 32];
          d_d     = privateKey[W-1 -: 32];
          c_d     = cipher[W-1 -: 32];
          valid_d = 1'b1;
          idx_d   = 6'd0;
        end
      end
      SEND: begin
        if (out_if.ready) begin
          count_d = count_q + 6'd1;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            valid_d = 1'b0;
            n_d     = 32'd0;
            d_d     = 32'd0;
            c_d     = 32'd0;
            idx_d   = 6'd0;
            done_d  = 1'b1;
          end else begin
            np_d    = np_sh;
            dp_d    = dp_sh;
            cp_d    = cp_sh;
            n_d     = np_sh[W-1 -: 32];
            d_d     = dp_sh[W-1 -: 32];
            c_d     = cp_sh[W-1 -: 32];
            idx_d   = idx_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    last_d = valid_d && (idx_d == LAST_IDX);
    busy_d = (state_d == SEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      np_q    <= '0;
      dp_q    <= '0;
      cp_q    <= '0;
      n_q     <= '0;
      d_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      np_q    <= np_d;
      dp_q    <= dp_d;
      cp_q    <= cp_d;
      n_q     <= n_d;
      d_q     <= d_d;
      c_q     <= c_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  assign out_if.n     = n_q;
  assign out_if.d     = d_q;
  assign out_if.c     = c_q;
  assign out_if.valid = valid_q;
  assign out_if.last  = last_q;
  assign out_if.idx   = idx_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign count        = count_q;

endmodule
